// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 channel multiplexer with a manual select
// mode and an auto-scan mode that dwells DWELL enabled cycles on each channel
// and pulses wrap on the last sample of the final channel in each frame.
module mux_scan_nto1 #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int DWELL = 4,
  localparam int SW    = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]     dout,
  output logic [SW-1:0]        dout_ch,
  output logic                 valid,
  output logic                 wrap
);

  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int              NSLOT    = 2 ** SW;
  localparam logic [SW:0]     NCH_X    = (SW + 1)'(NCH);
  localparam logic [SW-1:0]   LAST_CH  = SW'(NCH - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  // Channel view of the flat bus; slots past NCH read as zero so an
  // out-of-range select can never pick up stray bits.
  logic [WIDTH-1:0] ch [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < NCH) begin : g_live
      assign ch[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SW-1:0]    dout_ch_q, dout_ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_ok;

  assign sel_ok = ({1'b0, sel} < NCH_X);

  // Next-state: hold everything when disabled (wrap always drops), manual
  // select parks the scan pointer on the chosen channel, scan walks ptr/cnt.
  always_comb begin
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (en) begin
      if (!mode) begin
        dout_d    = sel_ok ? ch[sel] : '0;
        dout_ch_d = sel;
        valid_d   = sel_ok;
        ptr_d     = sel_ok ? sel : '0;
        cnt_d     = '0;
      end else begin
        dout_d    = ch[ptr_q];
        dout_ch_d = ptr_q;
        valid_d   = 1'b1;
        wrap_d    = (ptr_q == LAST_CH) && (cnt_q == LAST_CNT);
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + SW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Output stage: every output and the scan state register here, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout    = dout_q;
  assign dout_ch = dout_ch_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule
